asu_result_checker: RTL

Hardware result checker for the add/shift unit (ASU): the receiving end of the ASU stimulus/response stream. A stimulus source pushes each expected 9-bit response {carry, out[7:0]} into a small expected-value FIFO when it issues an operand pair. The ASU's registered response is later presented with a valid strobe. The block pops, compares, counts mismatches and captures the first failure, then raises done/pass after PATTERN_NUM comparisons. It sits beside the ASU in on-chip self-test builds and replaces the behavioural pass/fail bookkeeping.

---
 rtl/asu_pkg.sv | 18 +
 rtl/asu_exp_fifo.sv | 49 ++++
 rtl/asu_result_checker.sv | 132 +++++++++++++
 3 files changed

// File: rtl/asu_pkg.sv
// Shared definitions for the add/shift unit, its stimulus source and the result checker.
package asu_pkg;

  localparam int unsigned ASU_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } asu_state_t;

  // ASU response as seen on the wire: {carry, out[7:0]}
  typedef struct packed {
    logic       carry;
    logic [7:0] out;
  } asu_resp_t;

endpackage

// File: rtl/asu_exp_fifo.sv
// Expected-response FIFO: wrap-bit pointers, synchronous clear, no push-through when full.
module asu_exp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head  = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/asu_result_checker.sv
// Pops expected ASU responses, compares them with the live response stream,
// counts mismatches and records the first failure of each run.
module asu_result_checker
  import asu_pkg::*;
#(
  parameter int unsigned PATTERN_NUM = 10,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned W           = ASU_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         exp_valid,
  input  logic [W-1:0] exp_data,
  output logic         exp_ready,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   error_count,
  output logic [7:0]   first_err_idx,
  output logic [W-1:0] first_err_got,
  output logic [W-1:0] first_err_exp,
  output logic         protocol_err
);

  asu_state_t   state;
  asu_state_t   state_next;
  logic         full;
  logic         empty;
  logic [W-1:0] head;
  logic [7:0]   idx;
  logic         active;
  logic         do_push;
  logic         do_pop;
  logic         underflow;
  logic         mismatch;
  logic         last_cmp;

  // The start cycle only clears; traffic in that cycle belongs to no run.
  always_comb begin
    active    = (state == ST_RUN) && !start;
    do_push   = active && exp_valid && !full;
    do_pop    = active && res_valid && !empty;
    underflow = active && res_valid && empty;
    mismatch  = (res_data !== head);
    last_cmp  = do_pop && (idx == 8'(PATTERN_NUM - 1));
  end

  asu_exp_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .push  (do_push),
    .din   (exp_data),
    .pop   (do_pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    exp_ready    = 1'b0;
    pass         = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy      = 1'b1;
        exp_ready = !full;
        if (start)
          state_next = ST_RUN;
        else if (last_cmp)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (error_count == 8'd0) && !protocol_err;
        if (start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // error_count never wraps back to zero, so zero still means "no failure captured yet".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      error_count   <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      protocol_err  <= 1'b0;
    end else if (start) begin
      idx           <= '0;
      error_count   <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      first_err_exp <= '0;
      protocol_err  <= 1'b0;
    end else begin
      if (do_pop) begin
        idx <= idx + 8'd1;
        if (mismatch) begin
          if (error_count != 8'hFF)
            error_count <= error_count + 8'd1;
          if (error_count == 8'd0) begin
            first_err_idx <= idx;
            first_err_got <= res_data;
            first_err_exp <= head;
          end
        end
      end
      if (underflow)
        protocol_err <= 1'b1;
    end
  end

endmodule
